// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Operation encodings, FSM state type and default operand width.
package mcycle_pkg;

    localparam int MCYCLE_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/mcycle_if.sv
// Request/result bundle for mcycle: operands and opcode in, results and status out.
// master drives requests, slave is the multiply/divide unit.
interface mcycle_if
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_step.sv
// One unsigned iteration: shift-add multiply or restoring shift-subtract divide (MCYCLE_DIV_EN).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the step.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
)
(
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0] sum;
`ifdef MCYCLE_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
`endif

    always_comb begin
        // Multiply: hi:lo is partial product : remaining multiplier bits
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
        // Divide: hi is partial remainder, lo shifts dividend out and quotient in
        rem_sh = {hi, lo[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = rem_sh[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end
endmodule

// File: rtl/mcycle.sv
// Iterative signed/unsigned multiplier and divider (divide built only with MCYCLE_DIV_EN).
// Latency: Start accepted at edge k -> Busy cycles k+1..k+WIDTH, Done pulse in cycle k+WIDTH+1.
// Backpressure: none; Start is ignored while Busy, accepted again from IDLE or DONE.
module mcycle
    import mcycle_pkg::*;
#(
    parameter int WIDTH = MCYCLE_WIDTH
)
(
    input  logic   CLK,
    input  logic   RESETn,
    mcycle_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state;
    logic [CW-1:0]      count;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   hi, lo, opnd, dividend;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [WIDTH-1:0]   res1_q, res2_q, res1_fin, res2_fin;
    logic               busy_q, done_q;

    logic               sgn_in, is_div_in, neg1_in, neg2_in;
    logic [WIDTH-1:0]   mag1_in, mag2_in;
    logic [2*WIDTH-1:0] prod_raw, prod_fin;

    // Signed ops iterate on magnitudes; signs are reapplied on the final step
    always_comb begin
        sgn_in    = ~bus.MCycleOp[0];
        is_div_in = bus.MCycleOp[1];
        neg1_in   = sgn_in & bus.Operand1[WIDTH-1];
        neg2_in   = sgn_in & bus.Operand2[WIDTH-1];
        mag1_in   = neg1_in ? -bus.Operand1 : bus.Operand1;
        mag2_in   = neg2_in ? -bus.Operand2 : bus.Operand2;
    end

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_comb begin
        prod_raw = {hi_nxt, lo_nxt};
        prod_fin = neg_q ? -prod_raw : prod_raw;
        res1_fin = prod_fin[WIDTH-1:0];
        res2_fin = prod_fin[2*WIDTH-1:WIDTH];
        if (is_div) begin
            // Zero divisor overrides the iteration: all-ones quotient, dividend as remainder
            if (div_zero) begin
                res1_fin = '1;
                res2_fin = dividend;
            end else begin
                res1_fin = neg_q ? -lo_nxt : lo_nxt;
                res2_fin = neg_r ? -hi_nxt : hi_nxt;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state    <= S_IDLE;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res1_q   <= '0;
            res2_q   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            dividend <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                    if (bus.Start) begin
                        count    <= '0;
                        is_div   <= is_div_in;
                        neg_q    <= neg1_in ^ neg2_in;
                        neg_r    <= neg1_in;
                        div_zero <= (bus.Operand2 == '0);
                        dividend <= bus.Operand1;
                        hi       <= '0;
                        lo       <= is_div_in ? mag1_in : mag2_in;
                        opnd     <= is_div_in ? mag2_in : mag1_in;
                        state    <= S_COMPUTE;
                        busy_q   <= 1'b1;
`ifndef MCYCLE_DIV_EN
                        if (is_div_in) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            res1_q <= '0;
                            res2_q <= '0;
                        end
`endif
                    end
                end
                S_COMPUTE: begin
                    hi    <= hi_nxt;
                    lo    <= lo_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        res1_q <= res1_fin;
                        res2_q <= res2_fin;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_mcycle.sv
// Directed bench for mcycle: latency, Busy width, result hold, back-to-back, reset abort.
// Divide vectors expect real results when MCYCLE_DIV_EN is defined, zeros otherwise.
module tb_mcycle;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] prev1 = '0;
    logic [W-1:0] prev2 = '0;

    mcycle_if #(.WIDTH(W)) bus ();

    mcycle #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called in cycle k+1; returns cycle index of the Done pulse, Busy cycles, result changes
    task automatic wait_done(output int cyc, output int nb, output int chg);
        cyc = 1; nb = 0; chg = 0;
        while (!bus.Done && cyc < 100) begin
            if (bus.Busy) nb++;
            if (bus.Result1 !== prev1 || bus.Result2 !== prev2) chg++;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e1, input logic [W-1:0] e2,
                          input int elat, input int ebusy);
        int cyc, nb, chg;
        @(negedge CLK);
        bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
        @(negedge CLK);
        bus.Start = 1'b0; bus.Operand1 = ~a; bus.Operand2 = b ^ 32'h5;
        wait_done(cyc, nb, chg);
        chk({tag, "_lat"}, 64'(cyc), 64'(elat));
        chk({tag, "_busy"}, 64'(nb), 64'(ebusy));
        chk({tag, "_hold"}, 64'(chg), 64'd0);
        chk({tag, "_r1"}, 64'(bus.Result1), 64'(e1));
        chk({tag, "_r2"}, 64'(bus.Result2), 64'(e2));
        prev1 = e1; prev2 = e2;
        @(negedge CLK);
        chk({tag, "_pulse"}, 64'(bus.Done), 64'd0);
        chk({tag, "_keep"}, 64'({bus.Result2, bus.Result1}), {e2, e1});
    endtask

    initial begin
        int cyc, nb, chg, ndone;
        bus.Start = 1'b1; bus.MCycleOp = OP_UMUL; bus.Operand1 = 32'd9; bus.Operand2 = 32'd9;
        repeat (3) @(negedge CLK);
        chk("rst_r1", 64'(bus.Result1), 64'd0);
        chk("rst_r2", 64'(bus.Result2), 64'd0);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        bus.Start = 1'b0;
        RESETn = 1'b1;
        @(negedge CLK);
        chk("idle_busy", 64'(bus.Busy), 64'd0);

        run_op("umul_max", OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 32);
        run_op("smul_m3x7", OP_SMUL, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 33, 32);
        run_op("smul_minsq", OP_SMUL, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 33, 32);
        run_op("umul_shift", OP_UMUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 33, 32);
        run_op("smul_m1x1", OP_SMUL, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);
        run_op("smul_zero", OP_SMUL, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0, 33, 32);
`ifdef MCYCLE_DIV_EN
        run_op("sdiv_m7d2", OP_SDIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 32);
        run_op("sdiv_7dm2", OP_SDIV, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33, 32);
        run_op("udiv_100d0", OP_UDIV, 32'd100, 32'h0, 32'hFFFF_FFFF, 32'd100, 33, 32);
        run_op("sdiv_m5d0", OP_SDIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 33, 32);
        run_op("sdiv_ovf", OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33, 32);
        run_op("udiv_100d7", OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 33, 32);
        run_op("udiv_maxd1", OP_UDIV, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 33, 32);
`else
        run_op("sdiv_off", OP_SDIV, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 1, 0);
        run_op("udiv_off", OP_UDIV, 32'd100, 32'h0, 32'h0, 32'h0, 1, 0);
`endif
        run_op("umul_after", OP_UMUL, 32'd6, 32'd7, 32'd42, 32'd0, 33, 32);

        // Start held high with inputs changed mid-op, second op launched from DONE
        @(negedge CLK);
        bus.Start = 1'b1; bus.MCycleOp = OP_UMUL; bus.Operand1 = 32'd11; bus.Operand2 = 32'd13;
        @(negedge CLK);
        bus.MCycleOp = OP_SMUL; bus.Operand1 = 32'hFFFF_FFFE; bus.Operand2 = 32'd5;
        wait_done(cyc, nb, chg);
        chk("b2b1_lat", 64'(cyc), 64'd33);
        chk("b2b1_r", 64'({bus.Result2, bus.Result1}), {32'd0, 32'd143});
        prev1 = 32'd143; prev2 = 32'd0;
        @(negedge CLK);
        bus.Start = 1'b0;
        chk("b2b_nogap", 64'(bus.Busy), 64'd1);
        chk("b2b_pulse", 64'(bus.Done), 64'd0);
        wait_done(cyc, nb, chg);
        chk("b2b2_lat", 64'(cyc), 64'd33);
        chk("b2b2_busy", 64'(nb), 64'd32);
        chk("b2b2_hold", 64'(chg), 64'd0);
        chk("b2b2_r", 64'({bus.Result2, bus.Result1}), {32'hFFFF_FFFF, 32'hFFFF_FFF6});
        @(negedge CLK);

        // Reset at COMPUTE step 10, with Start asserted on the reset edge
        bus.Start = 1'b1; bus.MCycleOp = OP_UMUL; bus.Operand1 = 32'hFFFF; bus.Operand2 = 32'hFFFF;
        @(negedge CLK);
        bus.Start = 1'b0;
        repeat (9) @(negedge CLK);
        chk("abort_busy_pre", 64'(bus.Busy), 64'd1);
        RESETn = 1'b0; bus.Start = 1'b1;
        @(negedge CLK);
        chk("abort_busy", 64'(bus.Busy), 64'd0);
        chk("abort_done", 64'(bus.Done), 64'd0);
        chk("abort_res", 64'({bus.Result2, bus.Result1}), 64'd0);
        RESETn = 1'b1; bus.Start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.Done || bus.Busy) ndone++;
        end
        chk("abort_quiet", 64'(ndone), 64'd0);
        prev1 = '0; prev2 = '0;
        run_op("umul_post", OP_UMUL, 32'd3, 32'd5, 32'd15, 32'd0, 33, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
